// File: rtl/ram_pkg.sv
// Shared defaults for the RAM-subsystem blocks (request controller, response buffer).
package ram_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int RESP_DEPTH = 4;

  // Pointer advance with explicit wrap so non-power-of-two depths stay correct.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response buffer: push/pop with full/empty/count, storage cleared on reset.
module resp_fifo
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int DEPTH      = ram_pkg::RESP_DEPTH,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= PW'(wrap_inc(32'(wr_ptr), DEPTH));
      end
      if (do_pop) rd_ptr <= PW'(wrap_inc(32'(rd_ptr), DEPTH));
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_req_ctrl.sv
// Request controller for a single-port RAM with registered read data; reads return
// in order through a credit-limited response FIFO.
module ram_req_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
  parameter int RESP_DEPTH = ram_pkg::RESP_DEPTH,
  localparam int OW        = $clog2(RESP_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [OW-1:0]         outstanding
);

  logic          run_q;
  logic          inflight_q;
  logic [OW-1:0] outst_q;
  logic          accept;
  logic          rd_accept;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [OW-1:0] fifo_count;

  // run_q holds ready low during reset and rises on the first edge after release.
  assign req_ready   = run_q && (outst_q < OW'(RESP_DEPTH));
  assign accept      = req_valid && req_ready;
  assign rd_accept   = accept && !req_we;
  assign pop         = resp_valid && resp_ready;
  assign resp_valid  = !fifo_empty;
  assign outstanding = outst_q;

  assign ram_we   = accept && req_we;
  assign ram_addr = req_addr;
  assign ram_din  = req_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      outst_q    <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= rd_accept;
      case ({rd_accept, pop})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (ram_dout),
    .pop       (pop),
    .pop_data  (resp_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Credits cover both the in-flight slot and buffered entries, so a capture never meets a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_full && inflight_q));
  a_credit_sum:  assert property (@(posedge clk) disable iff (rst)
                                  outst_q == fifo_count + OW'(inflight_q));

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Scoreboard bench for ram_req_ctrl with a behavioural registered-read RAM.
module tb_ram_req_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 4;
  localparam int OW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [OW-1:0] outstanding;

  ram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            acc;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            n_resp = 0;
  bit            chk_lat = 1'b0;
  logic [DW-1:0] ram[16];
  logic [DW-1:0] shadow[16];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid && resp_ready) begin
        check("resp_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.data);
          if (chk_lat) check("resp_latency", cyc - e.acc, 2);
          n_resp++;
        end
      end
      check("ram_we_gate", ram_we, int'(req_valid && req_ready && req_we));
    end
  end

  task automatic issue(input bit we, input int addr, input int d, input int exp, output int waits);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(addr);
    req_wdata = DW'(d);
    waits     = 0;
    @(negedge clk);
    while (!req_ready && waits <= 50) begin
      waits++;
      @(negedge clk);
    end
    if (waits > 50) check("accept_timeout", waits, 0);
    else if (!we) sb.push_back('{DW'(exp), cyc});
    if (we) shadow[addr] = DW'(d);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int acc;
    int nr;
    int base;
    bit got;
    logic [AW-1:0] a;

    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_ram_we", ram_we, 0);
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    // write then read same address on the next cycle
    resp_ready = 1'b1; chk_lat = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 3, 8'hA5, 0, w);
    issue(1'b0, 3, 0, 8'hA5, w);
    repeat (4) @(negedge clk);

    // preload value = addr, then 16 back-to-back reads
    for (int i = 0; i < 16; i++) issue(1'b1, i, i, 0, w);
    base = n_resp;
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, i, 0, i, w);
      check("b2b_ready_waits", w, 0);
    end
    repeat (5) @(negedge clk);
    check("b2b_resp_count", n_resp - base, 16);
    chk_lat = 1'b0;

    // backpressure: only RESP_DEPTH reads accepted
    resp_ready = 1'b0;
    @(posedge clk); #1;
    acc = 0; a = 4'd4;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    repeat (10) begin
      @(negedge clk);
      got = req_ready;
      if (got) begin
        sb.push_back('{DW'(a), cyc});
        acc++;
      end
      @(posedge clk); #1;
      if (got) a = a + 1'b1;
      req_addr = a;
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_accepted", acc, 4);
    check("bp_req_ready", req_ready, 0);
    check("bp_outstanding", outstanding, 4);
    resp_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("bp_ready_back", req_ready, 1);
    check("bp_drained", sb.size(), 0);
    check("bp_outstanding_0", outstanding, 0);

    // simultaneous read accept and pop at outstanding=2
    resp_ready = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 8, 0, 8, w);
    issue(1'b0, 9, 0, 9, w);
    repeat (3) @(negedge clk);
    check("sim_outstanding_pre", outstanding, 2);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    issue(1'b0, 10, 0, 10, w);
    check("sim_outstanding_post", outstanding, 2);
    repeat (5) @(negedge clk);
    check("sim_drained", sb.size(), 0);

    // reset with three reads outstanding
    resp_ready = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 1, 0, 1, w);
    issue(1'b0, 2, 0, 2, w);
    issue(1'b0, 5, 0, 5, w);
    @(negedge clk);
    check("mid_outstanding", outstanding, 3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_outstanding", outstanding, 0);
    check("mid_rst_req_ready", req_ready, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    base = n_resp;
    repeat (8) @(negedge clk);
    check("no_stale_resp", n_resp - base, 0);
    check("no_stale_valid", resp_valid, 0);
    @(posedge clk); #1;
    issue(1'b0, 2, 0, 2, w);
    repeat (4) @(negedge clk);
    check("post_rst_resp", n_resp - base, 1);

    // 100 writes/reads interleaved, each read follows a write to the same address
    base = n_resp; nr = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 2) begin
        issue(1'b0, (i - 1) % 16, 0, shadow[(i - 1) % 16], w);
        nr++;
      end else begin
        issue(1'b1, i % 16, (i * 7) & 255, 0, w);
      end
    end
    repeat (6) @(negedge clk);
    check("mix_resp_count", n_resp - base, nr);
    check("mix_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_req_ctrl.md
RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: RAM address width.
REQ-003 SHALL have parameter RESP_DEPTH, default 4: response FIFO entries; legal values 2, 4 or 8.
REQ-004 SHALL have port clk  input  1  sole clock; all state on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  upstream request present.
REQ-007 SHALL have port req_ready  output  1  controller can accept a request.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH  request address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port resp_valid  output  1  read data available.
REQ-012 SHALL have port resp_ready  input  1  downstream accepts read data.
REQ-013 SHALL have port resp_rdata  output  DATA_WIDTH  read data, in request order.
REQ-014 SHALL have port ram_we  output  1  RAM write enable.
REQ-015 SHALL have port ram_addr  output  ADDR_WIDTH  RAM address.
REQ-016 SHALL have port ram_din  output  DATA_WIDTH  RAM write data.
REQ-017 SHALL have port ram_dout  input  DATA_WIDTH  RAM registered read data, valid one cycle after the address is presented.
REQ-018 SHALL have port outstanding  output  $clog2(RESP_DEPTH)+1  reads in flight plus reads buffered.

Function
REQ-019 SHALL accept a request on a rising edge only when req_valid and req_ready are both high.
REQ-020 SHALL drive req_ready = (outstanding < RESP_DEPTH), from registered state only, with no combinational dependence on req_valid, req_we or resp_ready.
REQ-021 SHALL drive ram_addr = req_addr and ram_din = req_wdata combinationally at all times.
REQ-022 SHALL drive ram_we = req_valid & req_ready & req_we.
REQ-023 SHALL generate no response for writes; a write does not change outstanding.
REQ-024 SHALL, for a read accepted at edge N, set a one-bit in-flight flag at edge N and capture ram_dout into the response FIFO at edge N+1.
REQ-025 SHALL show the captured data on resp_rdata with resp_valid high in the cycle after edge N+1, giving 2-cycle accept-to-resp_valid latency.
REQ-026 SHALL pop one FIFO entry on each edge where resp_valid and resp_ready are both high.
REQ-027 SHALL update outstanding each edge as +1 on read accept and -1 on pop; a simultaneous read accept and pop leaves it unchanged.
REQ-028 SHALL sustain one read per cycle with resp_ready held high when RESP_DEPTH >= 3.
REQ-029 SHALL, when the FIFO is full, hold req_ready low; the credit rule guarantees that no capture is lost.
REQ-030 SHALL, when the FIFO is empty, hold resp_valid low; resp_rdata is don't-care while resp_valid is low.
REQ-031 SHALL wrap the FIFO read and write pointers modulo RESP_DEPTH.
REQ-032 SHALL make a read accepted one cycle after a write to the same address return the newly written data.
REQ-033 SHALL return responses strictly in acceptance order.

Reset
REQ-034 SHALL, while rst is high, asynchronously clear outstanding, the in-flight flag, both FIFO pointers and the FIFO count, forcing req_ready=0, resp_valid=0 and ram_we=0.
REQ-035 SHALL discard reads in flight or buffered when rst asserts mid-operation; no stale response appears after release.
REQ-036 SHALL allow req_ready to rise in the first cycle after rst deasserts.
REQ-037 SHALL reset resp_rdata storage to 0.

Structure
REQ-038 SHALL place DATA_WIDTH, ADDR_WIDTH and RESP_DEPTH default constants in a shared package, ram_pkg, used by all RAM-subsystem blocks.
REQ-039 SHALL implement the response buffer as sub-module resp_fifo: synchronous, RESP_DEPTH entries, push/pop/full/empty/count, asynchronous reset.
REQ-040 SHALL keep credit accounting and RAM port drive in ram_req_ctrl, and not in resp_fifo.

Verification
REQ-041 SHALL cover: write addr 3 = 0xA5, then read addr 3 on the next cycle, resp_ready=1 -> resp_valid 2 cycles after the read accept, resp_rdata=0xA5.
REQ-042 SHALL cover: 16 back-to-back reads of addr 0..15 preloaded with value = addr, resp_ready=1, RESP_DEPTH=4 -> req_ready never drops, 16 responses 0x00..0x0F in order on consecutive cycles.
REQ-043 SHALL cover: resp_ready=0 while issuing reads -> exactly 4 accepted, req_ready=0, outstanding=4; raise resp_ready -> 4 in-order responses, then req_ready=1.
REQ-044 SHALL cover: simultaneous read accept and pop with outstanding=2 -> outstanding stays 2.
REQ-045 SHALL cover: assert rst with 3 reads outstanding -> resp_valid=0, outstanding=0 immediately; after release, no response appears until a new read is issued.
REQ-046 SHALL cover: 100 writes interleaved with reads -> resp_valid never rises for writes, and ram_we is high only on accepted writes.
